// File: rtl/mult_div_if.sv
// Handshake and register-file bus between the issuing pipeline and the
// HI/LO multiply-divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Issuing side: requests operations and moves, reads HI/LO and status.
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed MULT / DIV unit with HI/LO registers.
// Operands are converted to magnitudes at start, processed for WIDTH cycles
// (shift-add or restoring division), then sign-corrected in a FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [5:0]         cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Operand magnitudes; negating the most negative value yields its own
  // bit pattern, which reads correctly as the unsigned magnitude.
  always_comb begin
    a_mag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;
  end

  // One iteration of the unsigned core: shift-add for MULT, restoring
  // subtract-and-shift for DIV. acc_lo holds multiplier / dividend bits
  // shifting out and product / quotient bits shifting in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    nxt_hi    = acc_hi;
    nxt_lo    = acc_lo;
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, abs_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, abs_b};
    if (op_q) begin
      if (div_shift >= {1'b0, abs_b}) begin
        nxt_hi = div_diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction applied in FIX: product negated on differing signs,
  // quotient likewise, remainder follows the dividend.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (sign_a ^ sign_b) prod = -prod;
    quo  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
    rem  = sign_a ? -acc_hi : acc_hi;
  end

  // Control FSM, datapath registers and HI/LO with registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register here is cleared on reset, including datapath
      // state, so an aborted operation leaves nothing behind.
      state  <= IDLE;
      op_q   <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      abs_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register
      // samples pre-edge values regardless of statement order.
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            if (bus.op && (bus.b == '0)) begin
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
            end else begin
              op_q   <= bus.op;
              sign_a <= bus.a[WIDTH-1];
              sign_b <= bus.b[WIDTH-1];
              abs_b  <= b_mag;
              acc_hi <= '0;
              acc_lo <= a_mag;
              cnt    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_q) begin
            hi_q <= rem;
            lo_q <= quo;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results from a
// plain-arithmetic reference model; a monitor pops them on every done pulse.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
    int          due;
    int          busy_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_run = 0;
  exp_t sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input bit op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_v, p, q, r;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.dbz = 1'b0;
    e.busy_cycles = 33;
    if (!op) begin
      p    = sa * sb_v;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi  = model_hi;
      e.lo  = model_lo;
      e.dbz = 1'b1;
      e.busy_cycles = 0;
    end else begin
      q    = sa / sb_v;
      r    = sa % sb_v;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Monitor: counts consecutive busy cycles and checks every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy) busy_run++;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
        check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
        check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
        check("latency", 64'(cyc), 64'(e.due));
        check("busy_cycles", 64'(busy_run), 64'(e.busy_cycles));
      end
    end else if (bus.div_by_zero) begin
      check("dbz_without_done", 64'd1, 64'd0);
    end
    if (!bus.busy) busy_run = 0;
  end

  // Issue one operation; called and returns at a negedge.
  task automatic do_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                       input bit mv = 1'b0, input logic [31:0] mv_data = '0);
    exp_t e;
    if (mv) begin
      model_hi = mv_data;
      model_lo = mv_data;
    end
    e = model(op, a, b);
    e.due = cyc + ((op && b == 32'd0) ? 1 : 34);
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    bus.op = op;  bus.a = a;  bus.b = b;  bus.start = 1'b1;
    bus.hi_we = mv; bus.lo_we = mv; bus.wdata = mv_data;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.a = $urandom(); bus.b = $urandom();
    wait_drain();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_hi",   {32'd0, bus.hi}, 64'd0);
    check("reset_lo",   {32'd0, bus.lo}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(1'b0, 32'd10, 32'd10);
    do_op(1'b0, -32'sd3, 32'd7);
    do_op(1'b1, 32'd100, 32'd7);
    do_op(1'b1, -32'sd7, 32'd2);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd0);

    // Moves, then divide by zero leaves them intact.
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    @(negedge clk);
    bus.lo_we = 1'b0;
    model_hi = 32'h11; model_lo = 32'h22;
    check("mthi", {32'd0, bus.hi}, 64'h11);
    check("mtlo", {32'd0, bus.lo}, 64'h22);
    do_op(1'b1, 32'd5, 32'd0);
    check("dbz_hi_kept", {32'd0, bus.hi}, 64'h11);
    check("dbz_lo_kept", {32'd0, bus.lo}, 64'h22);

    // Simultaneous move and start: result overwrites the move.
    do_op(1'b0, 32'd6, -32'sd9, 1'b1, 32'hDEAD_BEEF);

    // Moves while busy are ignored; second start while busy is ignored.
    begin
      exp_t e;
      e = model(1'b0, 32'd1234, 32'd5678);
      e.due = cyc + 34;
      sb.push_back(e);
      model_hi = e.hi; model_lo = e.lo;
      bus.op = 1'b0; bus.a = 32'd1234; bus.b = 32'd5678; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.op = 1'b1; bus.a = 32'd99; bus.b = 32'd3; bus.start = 1'b1;
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hAAAA_5555;
      @(negedge clk);
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      check("busy_hi_hold", {32'd0, bus.hi}, {32'd0, 32'hDEAD_BEEF == 32'hDEAD_BEEF ? model(1'b0, 32'd6, -32'sd9).hi : 32'd0});
      wait_drain();
    end

    // Reset mid-operation aborts with no done pulse.
    bus.op = 1'b0; bus.a = 32'd77; bus.b = 32'd88; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    check("abort_hi",   {32'd0, bus.hi}, 64'd0);
    check("abort_lo",   {32'd0, bus.lo}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    // Start in the very first cycle after reset release.
    do_op(1'b1, -32'sd1000, -32'sd33);

    // Randomized operations with occasional corner operands.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: ;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b);
    end

    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand width; all behaviour below is stated for WIDTH=32.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  input  1  0 = MULT (funct 0x18), 1 = DIV (funct 0x1A).
REQ-007 A  input  32  signed multiplicand or dividend, the same operand bus that feeds the ALU.
REQ-008 B  input  32  signed multiplier or divisor.
REQ-009 hi_we, lo_we  input  1 each  MTHI / MTLO write strobes.
REQ-010 wdata  input  32  data for the MTHI / MTLO writes.
REQ-011 hi, lo  output  32 each  HI and LO registers, read by MFHI / MFLO.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse when an operation completes.
REQ-014 div_by_zero  output  1  one-cycle pulse, coincident with done, when a DIV has B=0.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and FIX; busy = (state != IDLE).
REQ-016 Start acceptance: in IDLE, start=1 at edge N SHALL do all of the following:
- latch op and the sign bits of A and B;
- latch |A| and |B| as 32-bit unsigned values (|-2^31| = 0x80000000);
- clear the 6-bit iteration counter;
- go to CALC.
REQ-017 Exception to REQ-016: DIV with B=0 SHALL stay in IDLE, leave hi and lo unchanged, and drive done=1 and div_by_zero=1 for the cycle after edge N.
REQ-018 CALC SHALL perform one iteration per cycle for exactly 32 cycles:
- MULT uses unsigned shift-add;
- DIV uses unsigned restoring division.
The state SHALL move to FIX on the edge that completes the 32nd iteration (edge N+32).
REQ-019 FIX, at edge N+33, SHALL apply sign correction, write hi and lo, set done=1 for one cycle, and return to IDLE.
- Total latency from the start edge to the done cycle is 33 cycles.
- busy is high for exactly 33 cycles.
REQ-020 MULT result: {hi,lo} SHALL equal the 64-bit two's-complement product; the product is negated when the operand signs differ.
REQ-021 DIV result:
- lo SHALL be the quotient truncated toward zero; it is negative when the operand signs differ.
- hi SHALL be the remainder, carrying the sign of the dividend.
REQ-022 DIV of -2^31 by -1 SHALL give lo=0x80000000 and hi=0 (wraps silently, no flag).
REQ-023 A start asserted while busy=1 SHALL be ignored; it is not queued.
- The operand and op registers SHALL NOT change during CALC or FIX.
REQ-024 hi_we / lo_we:
- In IDLE, SHALL write wdata to hi / lo at the next edge.
- While busy, SHALL be ignored.
REQ-025 In IDLE, simultaneous start and hi_we/lo_we SHALL both take effect: the move is written first, and the operation result overwrites it at completion.
REQ-026 Except for REQ-025 and REQ-017, hi and lo SHALL change only at the FIX edge.
REQ-027 done and div_by_zero SHALL be registered outputs, low in every cycle except those defined above.

Reset
REQ-028 rst=1 at any edge SHALL have highest priority and SHALL set:
- state = IDLE;
- hi = 0, lo = 0;
- busy = 0, done = 0, div_by_zero = 0;
- the iteration counter and operand registers cleared.
REQ-029 rst asserted mid-CALC or in FIX SHALL abort the operation with no done pulse; start in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-030 A=10, B=10, op=0, start pulse -> busy for 33 cycles, then done=1 with hi=0x00000000 and lo=0x00000064.
REQ-031 A=-3, B=7, op=0 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done 33 cycles after start.
REQ-032 Signed DIV cases:
- A=100, B=7, op=1 -> lo=14, hi=2.
- A=-7, B=2, op=1 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Divide by zero: preload hi=0x11, lo=0x22 via hi_we/lo_we, then A=5, B=0, op=1 -> done=1 and div_by_zero=1 the next cycle; hi=0x11 and lo=0x22 unchanged; busy never rises.
REQ-034 Start while busy and reset mid-operation:
- Second start at cycle 10 of a MULT -> ignored; exactly one done pulse, with the result of the first operands.
- rst at cycle 20 -> hi=lo=0, busy=0, no done pulse.
